// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the direction codes, the FSM state encoding and a one-hot helper.
package instr_sequencer_pkg;

  // Direction codes, matching draw_sel and the key_dir bit positions
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PICK      = 3'd1,
    ST_DRAW      = 3'd2,
    ST_WAIT_DRAW = 3'd3,
    ST_RESPOND   = 3'd4,
    ST_OVER      = 3'd5
  } state_t;

  // One-hot key pattern that corresponds to a direction code
  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/instr_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps every cycle outside reset.
// Ports:
//   clk, reset : clock and synchronous active-high reset (loads SEED)
//   bits       : the low OUT_W bits of the LFSR state
module instr_lfsr #(
  parameter logic [7:0]  SEED  = 8'hA5,
  parameter int unsigned OUT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] bits
);

  logic [7:0] state;
  logic       feedback;

  assign feedback = state[7] ^ state[5] ^ state[4] ^ state[3];
  assign bits     = state[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= {state[6:0], feedback};
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Game-round sequencer: picks a pseudo-random instruction, pulses the chosen
// drawer, waits for it to finish, then times and judges the player's key while
// tracking score, lives and game-over.
// Optional feature macro: NOTNOT_INVERT_EN enables inverted ("NOT <dir>")
// instructions; without it draw_not stays 0 and only direct judging exists.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : level, begins a game from IDLE or OVER
//   key_dir     : one-hot player key [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
//   draw_done   : selected drawer has finished plotting
//   draw_start  : one-cycle drawer enable pulse
//   draw_sel    : instruction direction, draw_not: instruction is inverted
//   score/lives : rounds won (saturating) / remaining lives
//   round_ok/round_fail : one-cycle judgement pulses
//   game_over   : high while in OVER
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 50_000_000,
  parameter int unsigned LIVES_INIT    = 3,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] key_dir,
  input  logic       draw_done,
  output logic       draw_start,
  output logic [1:0] draw_sel,
  output logic       draw_not,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       round_ok,
  output logic       round_fail,
  output logic       game_over
);

`ifdef NOTNOT_INVERT_EN
  localparam int unsigned PICK_W = 3;
`else
  localparam int unsigned PICK_W = 2;
`endif
  localparam int unsigned TIMER_W = $clog2(WINDOW_CYCLES);

  state_t             state, state_next;
  logic [PICK_W-1:0]  pick_bits;
  logic [TIMER_W-1:0] timer;
  logic               load_game, load_timer, win, lose;
  logic               key_any, key_onehot, key_match, key_good;

  instr_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (PICK_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .bits  (pick_bits)
  );

  // Key judging: multi-hot never passes; inversion flips the match sense
  assign key_any    = (key_dir != 4'd0);
  assign key_onehot = key_any && ((key_dir & (key_dir - 4'd1)) == 4'd0);
  assign key_match  = (key_dir == dir_onehot(draw_sel));
  assign key_good   = key_onehot && (draw_not ? !key_match : key_match);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and round control
  always_comb begin
    state_next = state;
    load_game  = 1'b0;
    load_timer = 1'b0;
    win        = 1'b0;
    lose       = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          load_game  = 1'b1;
          state_next = ST_PICK;
        end
      end
      ST_PICK: state_next = ST_DRAW;
      ST_DRAW: state_next = ST_WAIT_DRAW;
      ST_WAIT_DRAW: begin
        if (draw_done) begin
          load_timer = 1'b1;
          state_next = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        // A key in the final timer cycle is still judged
        if (key_any) begin
          win  = key_good;
          lose = !key_good;
        end else if (timer == '0) begin
          lose = 1'b1;
        end
        if (win) begin
          state_next = ST_PICK;
        end else if (lose) begin
          state_next = (lives <= 2'd1) ? ST_OVER : ST_PICK;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs, score/lives, instruction latch and response timer
  always_ff @(posedge clk) begin
    if (reset) begin
      score      <= 8'd0;
      lives      <= 2'd0;
      draw_sel   <= DIR_UP;
      draw_not   <= 1'b0;
      draw_start <= 1'b0;
      round_ok   <= 1'b0;
      round_fail <= 1'b0;
      game_over  <= 1'b0;
      timer      <= '0;
    end else begin
      draw_start <= (state_next == ST_DRAW);
      round_ok   <= win;
      round_fail <= lose;
      game_over  <= (state_next == ST_OVER);

      if (load_game) begin
        score <= 8'd0;
        lives <= 2'(LIVES_INIT);
      end else begin
        if (win && (score != 8'hFF)) score <= score + 8'd1;
        if (lose) lives <= lives - 2'd1;
      end

      if (state == ST_PICK) begin
        draw_sel <= pick_bits[1:0];
`ifdef NOTNOT_INVERT_EN
        draw_not <= pick_bits[2];
`else
        draw_not <= 1'b0;
`endif
      end

      if (load_timer) begin
        timer <= TIMER_W'(WINDOW_CYCLES - 1);
      end else if ((state == ST_RESPOND) && (timer != '0)) begin
        timer <= timer - TIMER_W'(1);
      end
    end
  end

endmodule
